multicycle_ctrl_fsm: RTL
========================

// Module: multicycle_ctrl_fsm
// PURPOSE
//  Multi-cycle MIPS control sequencer. Replaces the single-cycle opcode decoder: it steps one
//  instruction through FETCH/DECODE/EXEC/MEM/WB over several clocks and drives the shared
//  ALU, register-file, IR, PC and unified-memory controls. Waits on a memory ready handshake.
//  Counts retired instructions and flags illegal opcodes and memory timeouts.
// PARAMETERS
//  CNT_W     32  width of retired-instruction counter
//  WAIT_MAX  15  max cycles a memory state waits for mem_ready; 0 = wait forever
// PORTS
//  clk         in   1      clock, rising edge
//  rst         in   1      synchronous reset, active-high
//  opcode      in   6      IR[31:26]; sampled in DECODE
//  zero        in   1      ALU zero flag, used in BRANCH
//  mem_ready   in   1      memory completes current read/write this cycle
//  mem_read    out  1      memory read strobe
//  mem_write   out  1      memory write strobe
//  iord        out  1      0 = address from PC, 1 = from ALUOut
//  ir_write    out  1      load IR
//  pc_en       out  1      load PC
//  pc_src      out  2      00 ALU result, 01 ALUOut (branch target), 10 jump target
//  alu_src_a   out  1      0 = PC, 1 = register A
//  alu_src_b   out  2      00 reg B, 01 const 4, 10 sign-ext imm, 11 sign-ext imm<<2
//  alu_op      out  2      00 add, 01 sub, 10 use funct
//  reg_dst     out  1      0 = rt, 1 = rd
//  mem_to_reg  out  1      0 = ALUOut, 1 = MDR
//  reg_write   out  1      register-file write enable
//  illegal     out  1      1-cycle pulse: unsupported opcode in DECODE
//  timeout     out  1      1-cycle pulse: memory wait exceeded WAIT_MAX
//  retired     out  CNT_W  instructions completed, wraps at 2^CNT_W
//  state       out  4      current state encoding (debug)
// BEHAVIOUR
//  States: IDLE=0 FETCH=1 DECODE=2 MEMADR=3 MEMRD=4 MEMWB=5 MEMWR=6 EXEC=7 ALUWB=8
//   BRANCH=9 ADDIEX=10 ADDIWB=11 JUMP=12. Unlisted outputs are 0 in each state.
//  Reset: state=IDLE, retired=0, wait counter=0; all outputs 0. IDLE -> FETCH next cycle.
//  FETCH: mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_src=00;
//   ir_write=pc_en=mem_ready; stay until mem_ready=1, then DECODE.
//  DECODE: alu_src_a=0, alu_src_b=11, alu_op=00. Next by opcode: 000000->EXEC,
//   100011/101011->MEMADR, 000100->BRANCH, 001000->ADDIEX, 000010->JUMP (macro only);
//   any other -> FETCH with illegal=1 that cycle; not counted as retired.
//  MEMADR: alu_src_a=1, alu_src_b=10, alu_op=00; -> MEMRD if LW else MEMWR (opcode held).
//  MEMRD: mem_read=1, iord=1; wait for mem_ready, then MEMWB.
//  MEMWB: reg_dst=0, mem_to_reg=1, reg_write=1; -> FETCH.
//  MEMWR: mem_write=1, iord=1; wait for mem_ready, then FETCH.
//  EXEC: alu_src_a=1, alu_src_b=00, alu_op=10; -> ALUWB. ALUWB: reg_dst=1, reg_write=1; -> FETCH.
//  BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_src=01, pc_en=zero; -> FETCH.
//  ADDIEX: alu_src_a=1, alu_src_b=10, alu_op=00; -> ADDIWB. ADDIWB: reg_dst=0, reg_write=1; -> FETCH.
//  Memory strobes held constant for the whole wait; ready=1 on first cycle = zero-wait.
//  Wait counter: cleared on entry to FETCH/MEMRD/MEMWR, +1 per cycle with mem_ready=0.
//   WAIT_MAX>0 and counter reaches WAIT_MAX with mem_ready=0: timeout=1, -> FETCH,
//   no ir_write/pc_en/reg_write, not retired. mem_ready=1 in that same cycle wins (normal completion).
//  retired +1 on the clock leaving MEMWB, MEMWR (mem_ready=1), ALUWB, BRANCH, ADDIWB, JUMP.
//  rst=1 in any state (incl. mid-wait): next cycle is IDLE; no write strobe in the reset cycle.
//  Latency with zero-wait memory: R/ADDI 4 cycles, LW 5, SW 4, BEQ 3, J 3.
// CONFIGURATION
//  MC_CTRL_JUMP_EN defined: opcode 000010 -> JUMP: pc_src=10, pc_en=1; -> FETCH; retired +1.
//  Not defined: JUMP state absent, 000010 treated as illegal (illegal pulse, -> FETCH).
// TESTING
//  rst held 2 cycles, mem_ready=1 -> all outputs 0 and state=0, then state=1 after first release cycle.
//  R-type 000000, mem_ready=1 -> states 1,2,7,8,1; reg_dst=1,reg_write=1 in ALUWB; retired 0->1.
//  LW 100011, mem_ready low 3 cycles in MEMRD -> mem_read=iord=1 held 4 cycles, then MEMWB mem_to_reg=1.
//  BEQ 000100 with zero=1 -> pc_en=1,pc_src=01 in BRANCH; zero=0 -> pc_en=0; retired +1 both cases.
//  Opcode 111111 -> illegal=1 one cycle, back to FETCH, retired unchanged; 000010 per macro setting.
//  WAIT_MAX=15, mem_ready=0 in MEMWR -> timeout pulse on 15th wait cycle, mem_write drops; rst mid-MEMRD -> IDLE.

Source files
------------

// File: rtl/multicycle_ctrl_fsm.sv
// -----------------------------------------------------------------------------
// multicycle_ctrl_fsm
//
// Multi-cycle MIPS control sequencer. It steps one instruction at a time
// through FETCH / DECODE / execute / memory / write-back states. It drives
// the shared ALU, register-file, IR, PC and unified-memory controls. Both
// memory accesses (instruction fetch and data read/write) wait on a
// mem_ready handshake. The block counts retired instructions and raises
// one-cycle pulses for illegal opcodes and memory timeouts.
//
// Build option:
//   MC_CTRL_JUMP_EN  when defined, opcode 000010 (J) runs through a JUMP
//                    state. When undefined, there is no JUMP state and J is
//                    reported as an illegal opcode.
//
// Parameters:
//   CNT_W     width of the retired-instruction counter
//   WAIT_MAX  max cycles a memory state waits for mem_ready (0 = forever)
//
// Ports:
//   clk, rst         clock (rising edge), synchronous active-high reset
//   opcode[5:0]      IR[31:26], decoded in DECODE and still held in MEMADR
//   zero             ALU zero flag, qualifies the branch PC load
//   mem_ready        memory completes the current read/write this cycle
//   mem_read/write   memory strobes
//   iord             memory address select: 0 = PC, 1 = ALUOut
//   ir_write, pc_en  IR load and PC load enables
//   pc_src[1:0]      00 ALU result, 01 ALUOut, 10 jump target
//   alu_src_a        0 = PC, 1 = register A
//   alu_src_b[1:0]   00 reg B, 01 const 4, 10 sext imm, 11 sext imm << 2
//   alu_op[1:0]      00 add, 01 sub, 10 use funct
//   reg_dst          0 = rt, 1 = rd
//   mem_to_reg       0 = ALUOut, 1 = MDR
//   reg_write        register-file write enable
//   illegal          1-cycle pulse: unsupported opcode seen in DECODE
//   timeout          1-cycle pulse: memory wait exceeded WAIT_MAX
//   retired          completed-instruction count (wraps)
//   state[3:0]       current state encoding (debug)
// -----------------------------------------------------------------------------
module multicycle_ctrl_fsm #(
  parameter int CNT_W    = 32,
  parameter int WAIT_MAX = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       opcode,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             mem_read,
  output logic             mem_write,
  output logic             iord,
  output logic             ir_write,
  output logic             pc_en,
  output logic [1:0]       pc_src,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic             reg_dst,
  output logic             mem_to_reg,
  output logic             reg_write,
  output logic             illegal,
  output logic             timeout,
  output logic [CNT_W-1:0] retired,
  output logic [3:0]       state
);

  typedef enum logic [3:0] {
    IDLE   = 4'd0,
    FETCH  = 4'd1,
    DECODE = 4'd2,
    MEMADR = 4'd3,
    MEMRD  = 4'd4,
    MEMWB  = 4'd5,
    MEMWR  = 4'd6,
    EXEC   = 4'd7,
    ALUWB  = 4'd8,
    BRANCH = 4'd9,
    ADDIEX = 4'd10,
    ADDIWB = 4'd11
`ifdef MC_CTRL_JUMP_EN
    ,
    JUMP   = 4'd12
`endif
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
`ifdef MC_CTRL_JUMP_EN
  localparam logic [5:0] OP_J     = 6'b000010;
`endif

  // The wait counter only has to reach WAIT_MAX-1 before the timeout fires.
  // With WAIT_MAX = 0 it just free-runs and its value is never used.
  localparam int WAIT_W = (WAIT_MAX < 2) ? 1 : $clog2(WAIT_MAX + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST =
    WAIT_W'((WAIT_MAX > 0) ? (WAIT_MAX - 1) : 0);

  state_e              state_q, state_d;
  logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic [CNT_W-1:0]    retired_q, retired_d;
  logic                retire;
  logic                wait_expired;

  // Expiry happens on the cycle the counter would reach WAIT_MAX. A
  // mem_ready in that same cycle takes priority as a normal completion.
  assign wait_expired = (WAIT_MAX > 0) && !mem_ready && (wait_cnt_q == WAIT_LAST);

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = '0;
    retire     = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    iord       = 1'b0;
    ir_write   = 1'b0;
    pc_en      = 1'b0;
    pc_src     = 2'b00;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    alu_op     = 2'b00;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
    illegal    = 1'b0;
    timeout    = 1'b0;

    case (state_q)
      IDLE: begin
        state_d = FETCH;
      end

      // The PC+4 increment is computed in the same cycle as the instruction
      // read. IR and PC load only when the fetch actually completes.
      FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        ir_write  = mem_ready;
        pc_en     = mem_ready;
        if (mem_ready) begin
          state_d = DECODE;
        end else if (wait_expired) begin
          timeout = 1'b1;
          state_d = FETCH;
        end else begin
          wait_cnt_d = wait_cnt_q + WAIT_W'(1);
        end
      end

      // The branch target (PC + imm<<2) is computed speculatively here, so
      // BRANCH can take it from ALUOut.
      DECODE: begin
        alu_src_b = 2'b11;
        case (opcode)
          OP_RTYPE:      state_d = EXEC;
          OP_LW, OP_SW:  state_d = MEMADR;
          OP_BEQ:        state_d = BRANCH;
          OP_ADDI:       state_d = ADDIEX;
`ifdef MC_CTRL_JUMP_EN
          OP_J:          state_d = JUMP;
`endif
          default: begin
            illegal = 1'b1;
            state_d = FETCH;
          end
        endcase
      end

      MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        state_d   = (opcode == OP_LW) ? MEMRD : MEMWR;
      end

      MEMRD: begin
        mem_read = 1'b1;
        iord     = 1'b1;
        if (mem_ready) begin
          state_d = MEMWB;
        end else if (wait_expired) begin
          timeout = 1'b1;
          state_d = FETCH;
        end else begin
          wait_cnt_d = wait_cnt_q + WAIT_W'(1);
        end
      end

      MEMWB: begin
        mem_to_reg = 1'b1;
        reg_write  = 1'b1;
        retire     = 1'b1;
        state_d    = FETCH;
      end

      // A store retires on the cycle the memory accepts it. There is no
      // separate write-back state.
      MEMWR: begin
        mem_write = 1'b1;
        iord      = 1'b1;
        if (mem_ready) begin
          retire  = 1'b1;
          state_d = FETCH;
        end else if (wait_expired) begin
          timeout = 1'b1;
          state_d = FETCH;
        end else begin
          wait_cnt_d = wait_cnt_q + WAIT_W'(1);
        end
      end

      EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
        state_d   = ALUWB;
      end

      ALUWB: begin
        reg_dst   = 1'b1;
        reg_write = 1'b1;
        retire    = 1'b1;
        state_d   = FETCH;
      end

      // The ALU subtracts A-B to produce the zero flag. The PC takes the
      // target held in ALUOut when the flag is set.
      BRANCH: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b01;
        pc_src    = 2'b01;
        pc_en     = zero;
        retire    = 1'b1;
        state_d   = FETCH;
      end

      ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        state_d   = ADDIWB;
      end

      ADDIWB: begin
        reg_write = 1'b1;
        retire    = 1'b1;
        state_d   = FETCH;
      end

`ifdef MC_CTRL_JUMP_EN
      JUMP: begin
        pc_src  = 2'b10;
        pc_en   = 1'b1;
        retire  = 1'b1;
        state_d = FETCH;
      end
`endif

      default: begin
        state_d = IDLE;
      end
    endcase

    // While reset is asserted, every strobe is held low. This stops a store
    // that was interrupted mid-wait from writing during the reset cycle.
    if (rst) begin
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      iord       = 1'b0;
      ir_write   = 1'b0;
      pc_en      = 1'b0;
      pc_src     = 2'b00;
      alu_src_a  = 1'b0;
      alu_src_b  = 2'b00;
      alu_op     = 2'b00;
      reg_dst    = 1'b0;
      mem_to_reg = 1'b0;
      reg_write  = 1'b0;
      illegal    = 1'b0;
      timeout    = 1'b0;
    end
  end

  always_comb begin
    retired_d = retired_q;
    if (retire) begin
      retired_d = retired_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      wait_cnt_q <= '0;
      retired_q  <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      retired_q  <= retired_d;
    end
  end

  assign retired = retired_q;
  assign state   = state_q;

endmodule
